// File: rtl/gs_pkg.sv
// Shared types and constants for the GS pipeline front end.
package gs_pkg;

  localparam int unsigned GS_ADDR_W = 32;
  localparam int unsigned GS_WORD_W = 32;

  // PC fetched first after reset.
  localparam logic [GS_ADDR_W-1:0] GS_BOOT_ADDR = 32'h0000_0000;

  // Fetch request sequencer states.
  typedef enum logic [1:0] {
    IF_IDLE,
    IF_REQ,
    IF_WAIT,
    IF_DRAIN
  } if_state_t;

  // One queued instruction with the PC it was fetched from.
  typedef struct packed {
    logic [GS_ADDR_W-1:0] pc;
    logic [GS_WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/gs_fetch_fifo.sv
// Small synchronous FIFO of fetch entries. Depth must be a power of two so
// the pointers wrap naturally. Clear empties the queue and wins over push/pop.
module gs_fetch_fifo
  import gs_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  fetch_entry_t                 push_data_i,
  input  logic                         pop_i,
  input  logic                         clear_i,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output fetch_entry_t                 head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;

  // Storage, pointers and occupancy; storage is zeroed so outputs read 0 in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/gs_if_stage.sv
// GS instruction-fetch stage: owns the fetch PC, issues one request at a time
// on a req/gnt/rvalid interface, queues returned words and presents them to
// decode. Redirects flush the queue and drain any in-flight response.
// Optional build macro GS_IF_PERF_CNT_EN adds fetch/redirect event counters.
module gs_if_stage
  import gs_pkg::*;
#(
  parameter int unsigned          ADDR_SIZE = 32,
  parameter int unsigned          WORD_SIZE = 32,
  parameter logic [ADDR_SIZE-1:0] BOOT_ADDR = GS_BOOT_ADDR,
  parameter int unsigned          BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req_o,
  output logic [ADDR_SIZE-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [WORD_SIZE-1:0] imem_rdata_i,
  input  logic                 redirect_i,
  input  logic [ADDR_SIZE-1:0] redirect_pc_i,
  input  logic                 halt_if_i,
  output logic [ADDR_SIZE-1:0] pc_o,
  output logic [ADDR_SIZE-1:0] pc_4_o,
  output logic [WORD_SIZE-1:0] instr_o,
  output logic                 if_valid_o
`ifdef GS_IF_PERF_CNT_EN
  ,
  output logic [31:0]          perf_fetched_o,
  output logic [31:0]          perf_redirect_o
`endif
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

  if_state_t            state_q, state_d;
  logic [ADDR_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_SIZE-1:0] req_pc_q, req_pc_d;

  logic                 push;
  logic                 pop;
  fetch_entry_t         push_entry;
  fetch_entry_t         head;
  logic [CntW-1:0]      fifo_count;
  logic [31:0]          occupancy;
  logic                 issue_ok;

  // Reserve a queue slot for the outstanding response so a push never overflows.
  assign occupancy = 32'(fifo_count) + 32'(state_q == IF_WAIT);
  assign issue_ok  = occupancy < BUF_DEPTH;

  // Request sequencing and fetch-PC update; redirect overrides the normal flow.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    imem_req_o  = 1'b0;
    imem_addr_o = '0;
    push        = 1'b0;

    case (state_q)
      IF_IDLE: state_d = IF_REQ;
      IF_REQ: begin
        if (issue_ok) begin
          imem_req_o  = 1'b1;
          imem_addr_o = fetch_pc_q;
          if (imem_gnt_i) begin
            req_pc_d = fetch_pc_q;
            state_d  = IF_WAIT;
          end
        end
      end
      IF_WAIT: begin
        if (imem_rvalid_i) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + ADDR_SIZE'(4);
          state_d    = IF_REQ;
        end
      end
      IF_DRAIN: begin
        if (imem_rvalid_i) begin
          state_d = IF_REQ;
        end
      end
      default: state_d = IF_IDLE;
    endcase

    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[ADDR_SIZE-1:2], 2'b00};
      push       = 1'b0;
      case (state_q)
        // A grant in the redirect cycle still produces a response we must swallow.
        IF_REQ:  state_d = (imem_req_o && imem_gnt_i) ? IF_DRAIN : IF_REQ;
        IF_WAIT: state_d = imem_rvalid_i ? IF_REQ : IF_DRAIN;
        default: ;
      endcase
    end
  end

  // Sequencer state and fetch PCs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IF_IDLE;
      fetch_pc_q <= BOOT_ADDR;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  assign push_entry = '{pc: req_pc_q, instr: imem_rdata_i};

  gs_fetch_fifo #(
    .Depth (BUF_DEPTH)
  ) u_fetch_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .clear_i     (redirect_i),
    .count_o     (fifo_count),
    .head_o      (head)
  );

  // Decode-facing view of the queue head; redirect kills it combinationally.
  assign if_valid_o = (fifo_count != '0) && !redirect_i;
  assign pop        = if_valid_o && !halt_if_i;
  assign pc_o       = head.pc;
  assign pc_4_o     = head.pc + ADDR_SIZE'(4);
  assign instr_o    = head.instr;

`ifdef GS_IF_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_redirect_q;

  // Event counters; both wrap on overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_q  <= '0;
      perf_redirect_q <= '0;
    end else begin
      if (push) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (redirect_i) begin
        perf_redirect_q <= perf_redirect_q + 32'd1;
      end
    end
  end

  assign perf_fetched_o  = perf_fetched_q;
  assign perf_redirect_o = perf_redirect_q;
`endif

endmodule

// File: tb/tb_gs_if_stage.sv
// Directed bench for gs_if_stage: behavioural instruction memory plus a
// scoreboard of expected PCs in presentation order.
module tb_gs_if_stage;

  localparam logic [31:0] Salt = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        halt_if_i;
  logic [31:0] pc_o;
  logic [31:0] pc_4_o;
  logic [31:0] instr_o;
  logic        if_valid_o;

  gs_if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_if_i     (halt_if_i),
    .pc_o          (pc_o),
    .pc_4_o        (pc_4_o),
    .instr_o       (instr_o),
    .if_valid_o    (if_valid_o)
  );

  initial forever #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  bit          resp_pend = 1'b0;
  int          resp_cnt = 0;
  logic [31:0] resp_addr = '0;
  int          rsp_delay = 0;
  bit          gnt_delay_mode = 1'b0;
  int          req_age = 0;
  bit          last_grant = 1'b0;
  int          grants = 0;
  bit          grab_req = 1'b0;
  logic [31:0] grabbed = '0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_addr = '0;
  int          consumed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_stream(input logic [31:0] base, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // One clock cycle, entered and left at posedge+1.
  task automatic cycle();
    logic [31:0] exp_pc;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    if (resp_pend) begin
      if (resp_cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = resp_addr ^ Salt;
        resp_pend     = 1'b0;
      end else begin
        resp_cnt--;
      end
    end
    #1;
    imem_gnt_i = gnt_delay_mode ? (imem_req_o && req_age >= 3) : 1'b1;
    #1;
    if (prev_hold) begin
      check("req_stable", 32'(imem_req_o), 1);
      check("addr_stable", imem_addr_o, prev_addr);
    end
    if (redirect_i) check("redirect_kill", 32'(if_valid_o), 0);
    if (if_valid_o && !halt_if_i) begin
      check("sb_avail", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        exp_pc = exp_q.pop_front();
        check("pc", pc_o, exp_pc);
        check("pc_4", pc_4_o, exp_pc + 32'd4);
        check("instr", instr_o, exp_pc ^ Salt);
        consumed++;
      end
    end
    if (grab_req && imem_req_o) begin
      grabbed  = imem_addr_o;
      grab_req = 1'b0;
    end
    last_grant = imem_req_o && imem_gnt_i;
    if (last_grant) begin
      resp_pend = 1'b1;
      resp_cnt  = rsp_delay;
      resp_addr = imem_addr_o;
      grants++;
    end
    prev_hold = imem_req_o && !imem_gnt_i && !redirect_i;
    prev_addr = imem_addr_o;
    if (imem_req_o && !imem_gnt_i && !redirect_i) req_age++;
    else req_age = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Advance until a grant whose response is cnt cycles away from delivery.
  task automatic wait_grant(input int cnt);
    bit found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle();
      found = last_grant && resp_pend && resp_cnt == cnt;
    end
    check("wait_grant_found", 32'(found), 1);
  endtask

  task automatic do_redirect(input logic [31:0] target, input logic [31:0] aligned);
    redirect_i    = 1'b1;
    redirect_pc_i = target;
    push_stream(aligned, 64);
    cycle();
    redirect_i = 1'b0;
    grab_req   = 1'b1;
  endtask

  initial begin
    int c0;
    bit found;
    rst           = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    halt_if_i     = 1'b0;
    #2;
    check("rst_req", 32'(imem_req_o), 0);
    check("rst_addr", imem_addr_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_pc_4", pc_4_o, 4);
    check("rst_instr", instr_o, 0);
    check("rst_valid", 32'(if_valid_o), 0);

    // Basic stream from BOOT_ADDR with always-gnt, 1-cycle memory.
    @(posedge clk);
    #1;
    rst = 1'b1;
    push_stream(32'h0, 64);
    check("idle_no_req", 32'(imem_req_o), 0);
    cycle();
    check("first_req", 32'(imem_req_o), 1);
    check("first_addr", imem_addr_o, 32'h0);
    cycle();
    check("lat_not_yet", 32'(if_valid_o), 0);
    cycle();
    check("lat_valid", 32'(if_valid_o), 1);
    check("lat_pc", pc_o, 32'h0);
    c0 = consumed;
    run(10);
    check("stream_progress", 32'(consumed - c0 >= 5), 1);

    // Decode stall: head held, issue throttled by queue occupancy.
    halt_if_i = 1'b1;
    grants    = 0;
    for (int i = 0; i < 6; i++) begin
      if (if_valid_o) check("halt_pc", pc_o, exp_q.size() != 0 ? exp_q[0] : 32'hFFFF_FFFF);
      if (i >= 4) check("halt_no_req", 32'(imem_req_o), 0);
      if (i == 5) check("halt_valid", 32'(if_valid_o), 1);
      cycle();
    end
    check("halt_grants_le2", 32'(grants <= 2), 1);
    halt_if_i = 1'b0;
    c0 = consumed;
    run(8);
    check("halt_release_progress", 32'(consumed - c0 >= 3), 1);

    // Redirect while waiting; the in-flight response lands one cycle later.
    rsp_delay = 1;
    wait_grant(1);
    rsp_delay = 0;
    do_redirect(32'h0000_0100, 32'h0000_0100);
    c0 = consumed;
    run(10);
    check("redir_wait_addr", grabbed, 32'h0000_0100);
    check("redir_wait_progress", 32'(consumed - c0 >= 2), 1);

    // Redirect coinciding with rvalid.
    wait_grant(0);
    do_redirect(32'h0000_0300, 32'h0000_0300);
    c0 = consumed;
    run(10);
    check("redir_rvalid_addr", grabbed, 32'h0000_0300);
    check("redir_rvalid_progress", 32'(consumed - c0 >= 2), 1);

    // Redirect coinciding with gnt; low target bits must be ignored.
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (imem_req_o) found = 1'b1;
      else cycle();
    end
    check("req_found", 32'(found), 1);
    do_redirect(32'h0000_0403, 32'h0000_0400);
    c0 = consumed;
    run(10);
    check("redir_gnt_addr", grabbed, 32'h0000_0400);
    check("redir_gnt_progress", 32'(consumed - c0 >= 2), 1);

    // Slow grant: address held, then retargeted by a redirect mid-wait.
    gnt_delay_mode = 1'b1;
    req_age        = 0;
    found          = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (imem_req_o) found = 1'b1;
      else cycle();
    end
    check("slow_req_found", 32'(found), 1);
    run(2);
    do_redirect(32'h0000_0200, 32'h0000_0200);
    check("slow_retarget_req", 32'(imem_req_o), 1);
    check("slow_retarget_addr", imem_addr_o, 32'h0000_0200);
    c0 = consumed;
    run(20);
    check("slow_progress", 32'(consumed - c0 >= 3), 1);
    gnt_delay_mode = 1'b0;
    run(4);

    // Asynchronous reset while waiting; stale response after release.
    rsp_delay = 1;
    wait_grant(1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(if_valid_o), 0);
    check("arst_pc", pc_o, 0);
    check("arst_pc_4", pc_4_o, 4);
    check("arst_instr", instr_o, 0);
    check("arst_req", 32'(imem_req_o), 0);
    check("arst_addr", imem_addr_o, 0);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    rsp_delay = 0;
    resp_pend = 1'b1;
    resp_cnt  = 0;
    resp_addr = 32'h0000_0040;
    prev_hold = 1'b0;
    req_age   = 0;
    push_stream(32'h0, 64);
    check("arst_idle_no_req", 32'(imem_req_o), 0);
    cycle();
    check("arst_restart_req", 32'(imem_req_o), 1);
    check("arst_restart_addr", imem_addr_o, 32'h0);
    c0 = consumed;
    run(10);
    check("arst_progress", 32'(consumed - c0 >= 3), 1);

    // PC wrap at the top of the address space.
    do_redirect(32'hFFFF_FFF8, 32'hFFFF_FFF8);
    c0 = consumed;
    run(16);
    check("wrap_progress", 32'(consumed - c0 >= 4), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
